rsa_job_arbiter: RTL and testbench

Shares a single rsa4k modular-exponentiation engine among N_REQ requesters. It selects one job at a time by round-robin, captures that job's operands, and screens out degenerate operands. It then sequences the engine through its reset/go/done protocol and returns the cypher to the owning requester with a one-cycle response strobe. The block sits between client logic (key-exchange or signing masters) and the rsa4k instance.

---
 rtl/rsa_job_arbiter.sv | 254 +++++++++++++++++++++++++
 tb/tb_rsa_job_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_job_arbiter.sv
// rsa_job_arbiter: round-robin front end that shares one rsa4k modular
// exponentiation engine among N_REQ requesters. It screens out degenerate
// operands, sequences the engine reset/go/done handshake and returns the
// result to the owning requester with a one-cycle strobe.
// Optional feature macro: RSA_ARB_TIMEOUT_EN (RUN-state watchdog).
module rsa_job_arbiter #(
  parameter int WIDTH          = 4096,
  parameter int N_REQ          = 2,
  parameter int CLR_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 33554432
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] message_in,
  input  logic [N_REQ*WIDTH-1:0] exponent_in,
  input  logic [N_REQ*WIDTH-1:0] modulus_in,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]       rsp_cypher,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   eng_reset,
  output logic                   eng_go,
  output logic [WIDTH-1:0]       eng_message,
  output logic [WIDTH-1:0]       eng_exponent,
  output logic [WIDTH-1:0]       eng_modulus,
  input  logic [WIDTH-1:0]       eng_cypher,
  input  logic                   eng_done
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [3:0] CLR_LAST = 4'(CLR_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    CLR   = 3'd2,
    RUN   = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [WIDTH-1:0]  msg_q, msg_d;
  logic [WIDTH-1:0]  exp_q, exp_d;
  logic [WIDTH-1:0]  mod_q, mod_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  rsp_cypher_q, rsp_cypher_d;
  logic              rsp_err_q, rsp_err_d;
  logic              busy_q, busy_d;
  logic              eng_reset_q, eng_reset_d;
  logic              eng_go_q, eng_go_d;
  logic [3:0]        clr_cnt_q, clr_cnt_d;
`ifdef RSA_ARB_TIMEOUT_EN
  logic [31:0]       to_cnt_q, to_cnt_d;
`endif

  logic              win_found_s;
  logic [PW-1:0]     win_s;
  logic [PW-1:0]     cand_s;
  logic [WIDTH-1:0]  win_msg_s, win_exp_s, win_mod_s;

  // One-hot decode of a requester index.
  function automatic logic [N_REQ-1:0] onehot_f(input logic [PW-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin winner search starting just after the last served requester,
  // plus operand mux for the winner.
  always_comb begin
    win_found_s = 1'b0;
    win_s       = '0;
    cand_s      = '0;
    win_msg_s   = '0;
    win_exp_s   = '0;
    win_mod_s   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_s = PW'((int'(rr_q) + k) % N_REQ);
      if (!win_found_s && req[cand_s]) begin
        win_found_s = 1'b1;
        win_s       = cand_s;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (win_s == PW'(i)) begin
        win_msg_s = message_in[i*WIDTH +: WIDTH];
        win_exp_s = exponent_in[i*WIDTH +: WIDTH];
        win_mod_s = modulus_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and registered-output computation for the job sequencer.
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    owner_d      = owner_q;
    msg_d        = msg_q;
    exp_d        = exp_q;
    mod_d        = mod_q;
    gnt_d        = '0;
    rsp_valid_d  = '0;
    rsp_cypher_d = rsp_cypher_q;
    rsp_err_d    = rsp_err_q;
    eng_reset_d  = 1'b0;
    eng_go_d     = 1'b0;
    clr_cnt_d    = clr_cnt_q;
`ifdef RSA_ARB_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_found_s) begin
          owner_d = win_s;
          msg_d   = win_msg_s;
          exp_d   = win_exp_s;
          mod_d   = win_mod_s;
          gnt_d   = onehot_f(win_s);
          state_d = CHECK;
        end else begin
          state_d = IDLE;
        end
      end
      CHECK: begin
        // Even (including zero) modulus is invalid; modulus 1 and exponent 0
        // have trivial results, so the engine is never started for them.
        if (mod_q[0] == 1'b0) begin
          rsp_cypher_d = '0;
          rsp_err_d    = 1'b1;
          rsp_valid_d  = onehot_f(owner_q);
          state_d      = RESP;
        end else if (mod_q == WIDTH'(1)) begin
          rsp_cypher_d = '0;
          rsp_err_d    = 1'b0;
          rsp_valid_d  = onehot_f(owner_q);
          state_d      = RESP;
        end else if (exp_q == '0) begin
          rsp_cypher_d = WIDTH'(1);
          rsp_err_d    = 1'b0;
          rsp_valid_d  = onehot_f(owner_q);
          state_d      = RESP;
        end else begin
          eng_reset_d = 1'b1;
          clr_cnt_d   = CLR_LAST;
          state_d     = CLR;
        end
      end
      CLR: begin
        if (clr_cnt_q == 4'd0) begin
          eng_go_d = 1'b1;
`ifdef RSA_ARB_TIMEOUT_EN
          to_cnt_d = 32'd0;
`endif
          state_d  = RUN;
        end else begin
          clr_cnt_d   = clr_cnt_q - 4'd1;
          eng_reset_d = 1'b1;
        end
      end
      RUN: begin
        if (eng_done) begin
          rsp_cypher_d = eng_cypher;
          rsp_err_d    = 1'b0;
          rsp_valid_d  = onehot_f(owner_q);
          state_d      = RESP;
`ifdef RSA_ARB_TIMEOUT_EN
        end else if (to_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          // Watchdog expiry: knock the engine back into reset for the
          // response cycle and report an error.
          rsp_cypher_d = '0;
          rsp_err_d    = 1'b1;
          rsp_valid_d  = onehot_f(owner_q);
          eng_reset_d  = 1'b1;
          state_d      = RESP;
        end else begin
          to_cnt_d = to_cnt_q + 32'd1;
          eng_go_d = 1'b1;
        end
`else
        end else begin
          eng_go_d = 1'b1;
        end
`endif
      end
      RESP: begin
        rr_d    = owner_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset holds the engine in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rr_q         <= PW'(N_REQ - 1);
      owner_q      <= '0;
      msg_q        <= '0;
      exp_q        <= '0;
      mod_q        <= '0;
      gnt_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_cypher_q <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      eng_reset_q  <= 1'b1;
      eng_go_q     <= 1'b0;
      clr_cnt_q    <= 4'd0;
`ifdef RSA_ARB_TIMEOUT_EN
      to_cnt_q     <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      owner_q      <= owner_d;
      msg_q        <= msg_d;
      exp_q        <= exp_d;
      mod_q        <= mod_d;
      gnt_q        <= gnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_cypher_q <= rsp_cypher_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
      eng_reset_q  <= eng_reset_d;
      eng_go_q     <= eng_go_d;
      clr_cnt_q    <= clr_cnt_d;
`ifdef RSA_ARB_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
`endif
    end
  end

  assign gnt          = gnt_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_cypher   = rsp_cypher_q;
  assign rsp_err      = rsp_err_q;
  assign busy         = busy_q;
  assign eng_reset    = eng_reset_q;
  assign eng_go       = eng_go_q;
  assign eng_message  = msg_q;
  assign eng_exponent = exp_q;
  assign eng_modulus  = mod_q;

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// Self-checking bench for rsa_job_arbiter with a small behavioural engine.
// Scoreboard: expected responses are queued when a job is launched and
// popped when rsp_valid fires.
module tb_rsa_job_arbiter;

  localparam int W   = 16;
  localparam int N   = 2;
  localparam int CLR = 2;
  localparam int TO  = 64;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] message_in, exponent_in, modulus_in;
  logic [N-1:0]   gnt, rsp_valid;
  logic [W-1:0]   rsp_cypher;
  logic           rsp_err, busy, eng_reset, eng_go;
  logic [W-1:0]   eng_message, eng_exponent, eng_modulus;
  logic [W-1:0]   eng_cypher;
  logic           eng_done;

  rsa_job_arbiter #(.WIDTH(W), .N_REQ(N), .CLR_CYCLES(CLR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req(req),
    .message_in(message_in), .exponent_in(exponent_in), .modulus_in(modulus_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_cypher(rsp_cypher), .rsp_err(rsp_err),
    .busy(busy), .eng_reset(eng_reset), .eng_go(eng_go),
    .eng_message(eng_message), .eng_exponent(eng_exponent), .eng_modulus(eng_modulus),
    .eng_cypher(eng_cypher), .eng_done(eng_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] oh;
    logic [W-1:0] cyp;
    logic         err;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference modular exponentiation for the engine model.
  function automatic logic [W-1:0] modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                          input logic [W-1:0] m);
    logic [31:0] r, x;
    if (m == 16'd0) return 16'd0;
    r = 32'd1 % {16'd0, m};
    x = {16'd0, b} % {16'd0, m};
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = (r * x) % {16'd0, m};
      x = (x * x) % {16'd0, m};
    end
    return r[W-1:0];
  endfunction

  // Behavioural engine: done (level) eng_lat RUN cycles after go, cleared by eng_reset.
  int eng_lat  = 10;
  bit eng_hang = 1'b0;
  int ecnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      eng_done   <= 1'b0;
      eng_cypher <= '0;
      ecnt       <= 0;
    end else if (eng_reset) begin
      eng_done <= 1'b0;
      ecnt     <= 0;
    end else if (eng_go && !eng_done && !eng_hang) begin
      if (ecnt >= eng_lat) begin
        eng_done   <= 1'b1;
        eng_cypher <= modexp(eng_message, eng_exponent, eng_modulus);
      end else begin
        ecnt <= ecnt + 1;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: event timestamps, counters and scoreboard pops.
  int rsp_cnt = 0, rsp_cyc = 0, gnt_cyc = 0, go_rise_cyc = 0, go_rises = 0;
  int done_cyc = 0, rst_hi = 0, busy_low = 0;
  bit go_prev = 1'b0, done_prev = 1'b0, outstanding = 1'b0;
  logic [N-1:0] gnt_log[$];
  always @(negedge clk) begin
    if (!reset) begin
      outstanding <= 1'b0;
    end else begin
      if (eng_go && !go_prev) begin
        go_rise_cyc <= cyc;
        go_rises    <= go_rises + 1;
      end
      if (eng_done && !done_prev) done_cyc <= cyc;
      if (eng_reset && busy) rst_hi <= rst_hi + 1;
      if (!busy) busy_low <= busy_low + 1;
      if (|gnt) begin
        gnt_log.push_back(gnt);
        gnt_cyc <= cyc;
        chk("gnt_while_outstanding", {63'd0, outstanding}, 64'd0);
        chk("gnt_onehot", {63'd0, $onehot(gnt)}, 64'd1);
        outstanding <= 1'b1;
      end
      if (|rsp_valid) begin
        rsp_cnt     <= rsp_cnt + 1;
        rsp_cyc     <= cyc;
        outstanding <= 1'b0;
        chk("rsp_onehot", {63'd0, $onehot(rsp_valid)}, 64'd1);
        if (sb.size() == 0) begin
          chk("rsp_unexpected_sb_size", 64'(sb.size()), 64'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_owner", 64'(rsp_valid), 64'(e.oh));
          chk("rsp_cypher", 64'(rsp_cypher), 64'(e.cyp));
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
        end
      end
    end
    go_prev   <= eng_go;
    done_prev <= eng_done;
  end

  task automatic set_ops(input int r, input logic [W-1:0] m, input logic [W-1:0] e,
                         input logic [W-1:0] md);
    message_in[r*W +: W]  = m;
    exponent_in[r*W +: W] = e;
    modulus_in[r*W +: W]  = md;
  endtask

  task automatic push_exp(input int r, input logic [W-1:0] c, input logic e);
    exp_t x;
    x.oh    = '0;
    x.oh[r] = 1'b1;
    x.cyp   = c;
    x.err   = e;
    sb.push_back(x);
  endtask

  // mode 0: engine job, 1: short-circuit, 2: watchdog timeout
  task automatic run_job(input string tag, input int r, input logic [W-1:0] m,
                         input logic [W-1:0] e, input logic [W-1:0] md,
                         input logic [W-1:0] xc, input logic xe, input int mode);
    int s, r0, g0, h0, gl0;
    bit got;
    logic [N-1:0] xoh;
    set_ops(r, m, e, md);
    push_exp(r, xc, xe);
    xoh = '0;
    xoh[r] = 1'b1;
    r0 = rsp_cnt; g0 = go_rises; h0 = rst_hi; gl0 = gnt_log.size();
    @(posedge clk); #1;
    req[r] = 1'b1;
    s = cyc + 1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk); #1;
      if (gnt_log.size() > gl0) got = 1'b1;
    end
    req[r] = 1'b0;
    chk({tag, "_gnt_seen"}, {63'd0, got}, 64'd1);
    if (got) begin
      chk({tag, "_gnt_cycle"}, 64'(gnt_cyc), 64'(s));
      chk({tag, "_gnt_value"}, 64'(gnt_log[gl0]), 64'(xoh));
    end
    for (int i = 0; i < 3000 && rsp_cnt == r0; i++) begin
      @(negedge clk); #1;
    end
    chk({tag, "_rsp_count"}, 64'(rsp_cnt), 64'(r0 + 1));
    if (mode == 1) begin
      chk({tag, "_rsp_cycle"}, 64'(rsp_cyc), 64'(s + 1));
      chk({tag, "_no_go"}, 64'(go_rises), 64'(g0));
    end else if (mode == 0) begin
      chk({tag, "_go_cycle"}, 64'(go_rise_cyc), 64'(s + 1 + CLR));
      chk({tag, "_clr_len"}, 64'(rst_hi - h0), 64'(CLR));
      chk({tag, "_rsp_after_done"}, 64'(rsp_cyc), 64'(done_cyc + 1));
    end else begin
      chk({tag, "_go_once"}, 64'(go_rises), 64'(g0 + 1));
      chk({tag, "_timeout_cycle"}, 64'(rsp_cyc), 64'(go_rise_cyc + TO));
    end
  endtask

  initial begin
    int r0, g0, gl0, b0;
    bit got;
    reset = 1'b0; req = '0;
    message_in = '0; exponent_in = '0; modulus_in = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_rsp_cypher", 64'(rsp_cypher), 64'd0);
    chk("rst_eng_go", 64'(eng_go), 64'd0);
    chk("rst_eng_reset", 64'(eng_reset), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_eng_modulus", 64'(eng_modulus), 64'd0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1;
    chk("eng_reset_release", 64'(eng_reset), 64'd0);

    run_job("single", 0, 16'd8, 16'd13, 16'd77, 16'd50, 1'b0, 0);
    chk("operands_held", 64'(eng_modulus), 64'd77);
    run_job("inverse", 1, 16'h0032, 16'd37, 16'd77, 16'd8, 1'b0, 0);
    run_job("deg_even_mod", 0, 16'd8, 16'd13, 16'd76, 16'd0, 1'b1, 1);
    run_job("deg_exp_zero", 0, 16'd8, 16'd0, 16'd77, 16'd1, 1'b0, 1);
    run_job("deg_mod_one", 0, 16'd8, 16'd13, 16'd1, 16'd0, 1'b0, 1);

    // Reset 100 cycles into RUN aborts the job with no response.
    eng_lat = 1000;
    set_ops(0, 16'd8, 16'd13, 16'd77);
    push_exp(0, 16'd50, 1'b0);
    r0 = rsp_cnt; g0 = go_rises;
    @(posedge clk); #1; req[0] = 1'b1;
    @(negedge clk); @(negedge clk); #1; req[0] = 1'b0;
    for (int i = 0; i < 20 && go_rises == g0; i++) begin
      @(negedge clk); #1;
    end
    chk("midrst_go_seen", 64'(go_rises), 64'(g0 + 1));
    repeat (100) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_eng_go", 64'(eng_go), 64'd0);
    chk("midrst_eng_reset", 64'(eng_reset), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_eng_message", 64'(eng_message), 64'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    #1;
    chk("midrst_no_rsp", 64'(rsp_cnt), 64'(r0));
    @(negedge clk); reset = 1'b1; eng_lat = 10;
    run_job("post_reset", 0, 16'd8, 16'd13, 16'd77, 16'd50, 1'b0, 0);

    // Contention: both requesting from reset; rr starts at N-1 so 0 wins first.
    @(negedge clk); reset = 1'b0;
    sb.delete();
    set_ops(0, 16'd8, 16'd13, 16'd77);
    set_ops(1, 16'h0032, 16'd37, 16'd77);
    push_exp(0, 16'd50, 1'b0); push_exp(1, 16'd8, 1'b0);
    push_exp(0, 16'd50, 1'b0); push_exp(1, 16'd8, 1'b0);
    req = 2'b11;
    r0 = rsp_cnt; gl0 = gnt_log.size();
    @(negedge clk); reset = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk); #1;
      if (gnt_log.size() > gl0) got = 1'b1;
    end
    b0 = busy_low;
    for (int i = 0; i < 3000 && rsp_cnt < r0 + 4; i++) begin
      @(negedge clk); #1;
    end
    req = 2'b00;
    chk("cont_rsp_count", 64'(rsp_cnt), 64'(r0 + 4));
    chk("cont_gnt_count", 64'(gnt_log.size()), 64'(gl0 + 4));
    if (gnt_log.size() >= gl0 + 4) begin
      chk("cont_order0", 64'(gnt_log[gl0]), 64'd1);
      chk("cont_order1", 64'(gnt_log[gl0 + 1]), 64'd2);
      chk("cont_order2", 64'(gnt_log[gl0 + 2]), 64'd1);
      chk("cont_order3", 64'(gnt_log[gl0 + 3]), 64'd2);
    end
    // Only the single IDLE cycle at each of the three hand-offs drops busy.
    chk("cont_busy_gaps", 64'(busy_low - b0), 64'd3);
    repeat (3) @(negedge clk);

`ifdef RSA_ARB_TIMEOUT_EN
    eng_hang = 1'b1;
    run_job("timeout", 0, 16'd8, 16'd13, 16'd77, 16'd0, 1'b1, 2);
    eng_hang = 1'b0;
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound so the bench can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
